// File: rtl/muldiv_sequencer.sv
// Iterative MIPS multiply/divide unit: 32-step shift-add multiply, restoring divide,
// HI/LO result registers and MTHI/MTLO writes.
module muldiv_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [5:0] F_MTHI = 6'h11;
  localparam logic [5:0] F_MTLO = 6'h13;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [63:0] acc;     // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [31:0] opb;     // multiplicand or divisor magnitude
  logic        op_div, neg_lo, neg_hi;

  logic        accept, is_md, is_sgn, is_dv, div_zero, rs_neg, rt_neg;
  logic [31:0] rs_mag, rt_mag;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] step_nxt, prod;
  logic [31:0] quo, rem;

  assign accept   = (state == IDLE) && start && !flush;
  assign is_md    = (funct[5:2] == 4'b0110);
  assign is_sgn   = !funct[0];
  assign is_dv    = funct[1];
  assign div_zero = is_dv && (rt_val == 32'd0);
  assign rs_neg   = is_sgn && rs_val[31];
  assign rt_neg   = is_sgn && rt_val[31];
  assign rs_mag   = rs_neg ? (~rs_val + 32'd1) : rs_val;
  assign rt_mag   = rt_neg ? (~rt_val + 32'd1) : rt_val;

  assign ready = (state == IDLE);
  assign busy  = (state == CALC) || (state == FIX);
  assign done  = (state == DONE);

  // One iteration of either algorithm; the 33-bit shifted remainder can exceed
  // 32 bits only when the subtraction succeeds, so 32 bits of storage suffice.
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
    div_shift = {acc[63:32], acc[31]};
    div_diff  = div_shift - {1'b0, opb};
    if (!op_div)
      step_nxt = {mul_sum, acc[31:1]};
    else if (div_diff[32])
      step_nxt = {div_shift[31:0], acc[30:0], 1'b0};
    else
      step_nxt = {div_diff[31:0], acc[30:0], 1'b1};
    prod = neg_lo ? (~acc + 64'd1) : acc;
    quo  = neg_lo ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem  = neg_hi ? (~acc[63:32] + 32'd1) : acc[63:32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && is_md) state_nxt = div_zero ? FIX : CALC;
      CALC: if (flush) state_nxt = IDLE;
            else if (cnt == 6'd31) state_nxt = FIX;
      FIX:  state_nxt = flush ? IDLE : DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= 6'd0;
      acc    <= 64'd0;
      opb    <= 32'd0;
      op_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (funct == F_MTHI) hi <= rs_val;
          if (funct == F_MTLO) lo <= rs_val;
          if (is_md) begin
            cnt    <= 6'd0;
            op_div <= is_dv;
            if (div_zero) begin
              // Pre-load the fixed result so FIX needs no special case.
              acc    <= {rs_val, 32'hFFFF_FFFF};
              neg_lo <= 1'b0;
              neg_hi <= 1'b0;
            end else begin
              acc    <= {32'd0, is_dv ? rs_mag : rt_mag};
              opb    <= is_dv ? rt_mag : rs_mag;
              neg_lo <= rs_neg ^ rt_neg;
              neg_hi <= is_dv ? rs_neg : (rs_neg ^ rt_neg);
            end
          end
        end
        CALC: begin
          cnt <= cnt + 6'd1;
          acc <= step_nxt;
        end
        FIX: if (!flush) begin
          if (op_div) begin
            hi <= rem;
            lo <= quo;
          end else begin
            hi <= prod[63:32];
            lo <= prod[31:0];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle controller for the MIPS multiply/divide group (MULT, MULTU, DIV, DIVU, MTHI, MTLO). It accepts an R-type funct code and two operands from the execute stage, runs an iterative 32-step shift-add multiply or restoring divide, and holds the HI/LO result registers that MFHI/MFLO read. It sits beside the single-cycle ALU and its control decoder, and stalls the pipeline through `busy` while a long operation is in flight.

## Interface
- No parameters; datapath width fixed at 32.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; accepted when `start && ready`.
- `funct` in 6: R-type funct code, sampled on accept.
- `rs_val` in 32: multiplicand or dividend, sampled on accept.
- `rt_val` in 32: multiplier or divisor, sampled on accept.
- `flush` in 1: synchronous abort of any in-flight operation.
- `ready` out 1: high only in IDLE.
- `busy` out 1: high in CALC and FIX; pipeline stall request.
- `done` out 1: one-cycle pulse on the edge HI/LO take a MULT/DIV result.
- `hi` out 32: HI register (product upper / remainder).
- `lo` out 32: LO register (product lower / quotient).

## Operation
- Funct decode: 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU, 0x11 MTHI, 0x13 MTLO. Any other funct with `start` is ignored with no state change. MFHI (0x10) and MFLO (0x12) need no request, because `hi`/`lo` are direct register outputs.
- States:
  - IDLE: accepts requests.
  - CALC: 32 iteration steps; 6-bit step counter counts 0..31.
  - FIX: sign correction and HI/LO write.
  - DONE: one cycle, `done`=1, returns to IDLE.
- MTHI/MTLO: on accept, `hi`/`lo` is written with `rs_val` at that edge. The state stays IDLE and `done` is not pulsed.
- Signed ops: operands are converted to magnitudes on accept, and result signs are recorded.
  - Product sign = sign(rs) XOR sign(rt).
  - Quotient sign = sign(rs) XOR sign(rt).
  - Remainder sign = sign(rs).
- Multiply: 64-bit accumulator, shift-add on the LSB of the multiplier, one bit per CALC cycle.
- Divide: restoring algorithm with a 33-bit partial remainder and one quotient bit per CALC cycle.
- FIX applies two's-complement negation where required, then writes HI/LO.
- Divide by zero (rt_val=0, DIV or DIVU):
  - Detected on accept; IDLE goes directly to FIX.
  - Result: `lo`=0xFFFF_FFFF, `hi`=rs_val unchanged, with no sign correction.
- DIV 0x8000_0000 / 0xFFFF_FFFF gives `lo`=0x8000_0000 and `hi`=0. This falls out of magnitude arithmetic and needs no special case.
- `start` while not ready: ignored. The requester holds its request, since `busy` stalls it.
- `flush` in CALC or FIX returns to IDLE on the next edge. HI/LO are not written and `done` is not pulsed.
  - `flush` with `start` in IDLE: the request is dropped, MTHI/MTLO included.
  - `flush` in DONE has no effect; HI/LO were already written.

## Timing
- Reset values: `hi`=0, `lo`=0, `ready`=1, `busy`=0, `done`=0; state IDLE, counter 0, accumulators 0.
- Assertion of `rst_n` low mid-operation takes effect immediately with no clock edge, aborts, and restores reset values.
- MULT/DIV latency:
  - Accept at edge 0; CALC for edges 1..32; FIX at edge 33, which writes HI/LO and enters DONE.
  - `done` is high during the cycle after edge 33. `ready` returns at edge 34.
  - Back-to-back issue is possible every 35 cycles.
- Divide-by-zero latency: accept at edge 0, FIX writes at edge 1, `done` high in the following cycle.
- `busy` rises in the cycle after accept and falls when DONE is entered.
- HI/LO change only at FIX writes, MTHI/MTLO, or reset.

## Test plan
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → `hi`=0xFFFF_FFFE, `lo`=0x0000_0001; `done` exactly 34 cycles after accept; `busy` high for 33 cycles.
- MULT −7 (0xFFFF_FFF9) × 6 → `hi`=0xFFFF_FFFF, `lo`=0xFFFF_FFD6; DIV −7 / 2 → `lo`=0xFFFF_FFFD, `hi`=0xFFFF_FFFF.
- DIVU 100 / 0 → `lo`=0xFFFF_FFFF, `hi`=100, `done` 2 cycles after accept; DIV 0x8000_0000 / −1 → `lo`=0x8000_0000, `hi`=0.
- MTHI 0x1234_5678 then MTLO 0xDEAD_BEEF on consecutive cycles → registers update on each edge, `ready` stays 1, `done` never pulses.
- Start DIVU, pulse `flush` at CALC step 10 → IDLE next edge, HI/LO keep their prior values, no `done`; a second `start` during CALC is ignored.
- Drive `rst_n` low mid-CALC between clock edges → outputs reach reset values immediately; after release, MULTU 3×5 gives `lo`=15, `hi`=0.
